// File: rtl/clock_pkg.sv
// Shared definitions for the clock top level: BCD digit width and the alarm
// ringer state encoding, also used by the timekeeper and alarm-setting blocks.
package clock_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } ring_state_e;
endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the clock top level (master) and the alarm ringer (slave).
interface alarm_ringer_if;
  import clock_pkg::*;

  // No valid/ready handshake here: sec_tick/min_tick are single-cycle strobes,
  // time/alarm digits and alarm_flag are levels, buttons are debounced levels
  // acted on at their rising edge, and all outputs are registered levels.
  logic             sec_tick;
  logic             min_tick;
  logic [BCD_W-1:0] hourten;
  logic [BCD_W-1:0] hour;
  logic [BCD_W-1:0] minten;
  logic [BCD_W-1:0] min;
  logic [BCD_W-1:0] alarm_hourten;
  logic [BCD_W-1:0] alarm_hour;
  logic [BCD_W-1:0] alarm_minten;
  logic [BCD_W-1:0] alarm_min;
  logic             alarm_flag;
  logic             btn_stop;
  logic             btn_snooze;
  logic             alarm_sound;
  logic             ringing;
  logic             snoozing;
  ring_state_e      dbg_state;

  modport master (
    output sec_tick, min_tick, hourten, hour, minten, min,
           alarm_hourten, alarm_hour, alarm_minten, alarm_min,
           alarm_flag, btn_stop, btn_snooze,
    input  alarm_sound, ringing, snoozing, dbg_state
  );

  modport slave (
    input  sec_tick, min_tick, hourten, hour, minten, min,
           alarm_hourten, alarm_hour, alarm_minten, alarm_min,
           alarm_flag, btn_stop, btn_snooze,
    output alarm_sound, ringing, snoozing, dbg_state
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone source: toggles every CLK_HZ/(2*TONE_HZ) cycles while
// enabled, and is held at zero (counter and output) while disabled.
module tone_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TONE_HZ = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tone
);
  localparam int HALF  = CLK_HZ / (2 * TONE_HZ);
  localparam int CNT_W = $clog2(HALF);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == CNT_W'(HALF - 1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: matches the running BCD time against the alarm time at each
// minute rollover and drives a gated tone through a ring/snooze state machine.
module alarm_ringer
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TONE_HZ     = 2000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 9
) (
  input  logic         CLK100MHZ,
  input  logic         btn_reset_n,
  alarm_ringer_if.slave bus
);
  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_MINS + 1);

  ring_state_e       state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snooze_cnt_q, snooze_cnt_d;
  logic              beep_gate_q, beep_gate_d;
  logic              stop_q, snooze_q;
  logic              stop_edge, snooze_edge;
  logic              match;
  logic              tone;
  logic              sound_q, ringing_q, snoozing_q;

  assign stop_edge   = bus.btn_stop & ~stop_q;
  assign snooze_edge = bus.btn_snooze & ~snooze_q;
  assign match = ({bus.hourten, bus.hour, bus.minten, bus.min} ==
                  {bus.alarm_hourten, bus.alarm_hour, bus.alarm_minten, bus.alarm_min});

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    beep_gate_d  = beep_gate_q;
    if (!bus.alarm_flag) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (bus.min_tick && match) begin
            state_d     = RINGING;
            ring_cnt_d  = '0;
            beep_gate_d = 1'b1;
          end
        end
        RINGING: begin
          // Button edges outrank the auto-off second tick.
          if (stop_edge) begin
            state_d = ARMED;
          end else if (snooze_edge) begin
            state_d      = SNOOZE;
            snooze_cnt_d = SNZ_W'(SNOOZE_MINS);
          end else if (bus.sec_tick) begin
            if (ring_cnt_q == RING_W'(RING_SECS - 1)) begin
              state_d = ARMED;
            end else begin
              ring_cnt_d  = ring_cnt_q + 1'b1;
              beep_gate_d = ~beep_gate_q;
            end
          end
        end
        SNOOZE: begin
          if (stop_edge) begin
            state_d = ARMED;
          end else if (bus.min_tick) begin
            snooze_cnt_d = snooze_cnt_q - 1'b1;
            if (snooze_cnt_q == SNZ_W'(1)) begin
              state_d     = RINGING;
              ring_cnt_d  = '0;
              beep_gate_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge btn_reset_n) begin
    if (!btn_reset_n) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      beep_gate_q  <= 1'b0;
      stop_q       <= 1'b1;
      snooze_q     <= 1'b1;
      sound_q      <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      beep_gate_q  <= beep_gate_d;
      stop_q       <= bus.btn_stop;
      snooze_q     <= bus.btn_snooze;
      // Decoding the next state lets a flag drop or snooze silence the pin on that same edge.
      sound_q      <= tone & beep_gate_q & (state_d == RINGING);
      ringing_q    <= (state_d == RINGING);
      snoozing_q   <= (state_d == SNOOZE);
    end
  end

  tone_gen #(
    .CLK_HZ (CLK_HZ),
    .TONE_HZ(TONE_HZ)
  ) u_tone_gen (
    .clk   (CLK100MHZ),
    .rst_n (btn_reset_n),
    .enable(state_q == RINGING),
    .tone  (tone)
  );

  assign bus.alarm_sound = sound_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: a sequential vector table for the FSM,
// plus hand-written sequences for tone timing, flag drop and mid-ring reset.
module tb_alarm_ringer;
  import clock_pkg::*;

  localparam int CLK_HZ      = 1000;
  localparam int TONE_HZ     = 100;
  localparam int RING_SECS   = 5;
  localparam int SNOOZE_MINS = 2;
  localparam int HALF        = 5;
  localparam logic [15:0] T_ON  = 16'h0730;
  localparam logic [15:0] T_OFF = 16'h0731;

  typedef struct {
    logic        flag;
    logic [15:0] tm;
    logic        sec;
    logic        mt;
    logic        stop;
    logic        snz;
    ring_state_e st;
    logic        ring;
    logic        snzo;
    logic        snd;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];
  int   m_cnt;
  logic m_tone;
  logic m_gate;
  logic last_exp;

  alarm_ringer_if bus ();

  alarm_ringer #(
    .CLK_HZ     (CLK_HZ),
    .TONE_HZ    (TONE_HZ),
    .RING_SECS  (RING_SECS),
    .SNOOZE_MINS(SNOOZE_MINS)
  ) dut (
    .CLK100MHZ  (clk),
    .btn_reset_n(rst_n),
    .bus        (bus)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_time(input logic [15:0] t);
    {bus.hourten, bus.hour, bus.minten, bus.min} = t;
  endtask

  task automatic add(input logic flag, input logic [15:0] tm, input logic sec,
                     input logic mt, input logic stop, input logic snz,
                     input ring_state_e st, input logic ring, input logic snzo,
                     input logic snd);
    vec_t v;
    v.flag = flag; v.tm = tm; v.sec = sec; v.mt = mt; v.stop = stop; v.snz = snz;
    v.st = st; v.ring = ring; v.snzo = snzo; v.snd = snd;
    tbl.push_back(v);
  endtask

  task automatic model_start();
    m_cnt  = 0;
    m_tone = 1'b0;
    m_gate = 1'b1;
  endtask

  // One ringing cycle: independent model of tone counter, gate and output register.
  task automatic tone_step(input logic sec);
    logic exp;
    exp = m_tone & m_gate;
    bus.sec_tick = sec;
    step();
    bus.sec_tick = 1'b0;
    chk("tone_sound", bus.alarm_sound, exp);
    chk("tone_ringing", bus.ringing, 1'b1);
    last_exp = exp;
    if (m_cnt == HALF - 1) begin
      m_cnt  = 0;
      m_tone = ~m_tone;
    end else begin
      m_cnt++;
    end
    if (sec) m_gate = ~m_gate;
  endtask

  task automatic trigger_ring();
    bus.alarm_flag = 1'b1;
    set_time(T_OFF);
    step();
    set_time(T_ON);
    bus.min_tick = 1'b1;
    step();
    bus.min_tick = 1'b0;
    chk("trigger_ringing", bus.ringing, 1'b1);
    chk("trigger_state", bus.dbg_state, RINGING);
    model_start();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.sec_tick = 1'b0;
    bus.min_tick = 1'b0;
    set_time(16'h0000);
    {bus.alarm_hourten, bus.alarm_hour, bus.alarm_minten, bus.alarm_min} = T_ON;
    bus.alarm_flag = 1'b0;
    bus.btn_stop   = 1'b1;
    bus.btn_snooze = 1'b0;

    // reset with stop held high
    repeat (3) step();
    chk("rst_sound", bus.alarm_sound, 1'b0);
    chk("rst_ringing", bus.ringing, 1'b0);
    chk("rst_snoozing", bus.snoozing, 1'b0);
    chk("rst_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    step();
    chk("post_rst_state", bus.dbg_state, IDLE);

    //   flag tm    sec mt stop snz  state    ring snz snd
    add(0, T_ON,  0, 1, 1, 0, IDLE,    0, 0, 0);
    add(1, T_ON,  0, 0, 1, 0, ARMED,   0, 0, 0);
    add(1, T_OFF, 0, 1, 0, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 0, 0, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, ARMED,   0, 0, 0);
    add(1, T_OFF, 0, 1, 0, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_ON,  0, 1, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 0, 0, 0, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 1, 0, 1, RINGING, 1, 0, 0);
    add(1, T_OFF, 0, 0, 1, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 0, 1, 1, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_ON,  0, 0, 1, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 1, 1, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 1, 0, 0, SNOOZE,  0, 1, 0);
    add(1, T_OFF, 0, 1, 1, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(0, T_ON,  0, 0, 0, 0, IDLE,    0, 0, 0);
    add(1, T_ON,  0, 0, 0, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  0, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(0, T_ON,  0, 0, 0, 0, IDLE,    0, 0, 0);
    add(1, T_OFF, 0, 0, 0, 0, ARMED,   0, 0, 0);
    add(1, T_ON,  0, 1, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 0, RINGING, 1, 0, 0);
    add(1, T_ON,  1, 0, 0, 1, SNOOZE,  0, 1, 0);
    add(0, T_ON,  0, 0, 0, 0, IDLE,    0, 0, 0);

    foreach (tbl[i]) begin
      bus.alarm_flag = tbl[i].flag;
      set_time(tbl[i].tm);
      bus.sec_tick   = tbl[i].sec;
      bus.min_tick   = tbl[i].mt;
      bus.btn_stop   = tbl[i].stop;
      bus.btn_snooze = tbl[i].snz;
      step();
      chk($sformatf("v%0d_state", i), bus.dbg_state, tbl[i].st);
      chk($sformatf("v%0d_ringing", i), bus.ringing, tbl[i].ring);
      chk($sformatf("v%0d_snoozing", i), bus.snoozing, tbl[i].snzo);
      chk($sformatf("v%0d_sound", i), bus.alarm_sound, tbl[i].snd);
    end
    bus.sec_tick   = 1'b0;
    bus.min_tick   = 1'b0;
    bus.btn_stop   = 1'b0;
    bus.btn_snooze = 1'b0;

    // tone cadence with beep gate, then alarm_flag drop while sounding
    trigger_ring();
    for (int k = 1; k <= 40; k++) tone_step(k == 14 || k == 27);
    for (int k = 0; k < 12 && last_exp !== 1'b1; k++) tone_step(1'b0);
    chk("sound_before_drop", bus.alarm_sound, 1'b1);
    bus.alarm_flag = 1'b0;
    step();
    chk("drop_sound", bus.alarm_sound, 1'b0);
    chk("drop_ringing", bus.ringing, 1'b0);
    chk("drop_state", bus.dbg_state, IDLE);

    // asynchronous reset while sounding
    trigger_ring();
    last_exp = 1'b0;
    for (int k = 0; k < 15 && last_exp !== 1'b1; k++) tone_step(1'b0);
    chk("sound_before_reset", bus.alarm_sound, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sound", bus.alarm_sound, 1'b0);
    chk("async_rst_ringing", bus.ringing, 1'b0);
    bus.alarm_flag = 1'b0;
    step();
    chk("async_rst_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    step();
    chk("after_rst_state", bus.dbg_state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
